// File: rtl/dsp48e_arb_pkg.sv
// Shared widths and rounding helper for the arbitrated multiply-add-round unit.
// Define CONV_ROUND_EN for convergent rounding; otherwise results are truncated.
package dsp48e_arb_pkg;

    localparam int A_W     = 25;
    localparam int B_W     = 18;
    localparam int C_W     = 48;
    localparam int P_W     = 48;
    localparam int OUT_W   = 44;
    localparam int FRAC_W  = 4;
    localparam logic [FRAC_W-1:0] TIE_VAL = 4'b1000;

    // Drops the fraction bits; the increment wraps modulo 2^OUT_W on overflow.
    function automatic logic [OUT_W-1:0] round_res(input logic [P_W-1:0] p);
        logic up_s;
`ifdef CONV_ROUND_EN
        if (p[FRAC_W-1:0] > TIE_VAL) begin
            up_s = 1'b1;
        end else if (p[FRAC_W-1:0] == TIE_VAL) begin
            up_s = p[FRAC_W];
        end else begin
            up_s = 1'b0;
        end
`else
        up_s = 1'b0;
`endif
        return p[P_W-1:FRAC_W] + {{(OUT_W-1){1'b0}}, up_s};
    endfunction

endpackage

// File: rtl/mult_round_pipe.sv
// PIPE_LAT-stage multiply-add-round datapath with per-stage valid and requester tags.
// Rounding mode follows CONV_ROUND_EN through dsp48e_arb_pkg::round_res.
module mult_round_pipe
    import dsp48e_arb_pkg::*;
#(
    parameter int PIPE_LAT = 3,
    parameter int IDW      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  acc_vld,
    input  logic signed [A_W-1:0] a_op,
    input  logic signed [B_W-1:0] b_op,
    input  logic signed [C_W-1:0] c_op,
    input  logic [IDW-1:0]        acc_id,
    output logic                  res_vld,
    output logic [OUT_W-1:0]      res,
    output logic [IDW-1:0]        res_id,
    output logic                  any_vld
);

    logic [PIPE_LAT-1:0]   vld_r;
    logic [IDW-1:0]        id_r  [0:PIPE_LAT-1];
    logic signed [P_W-1:0] mul_r;
    logic signed [P_W-1:0] c_r;
    logic [OUT_W-1:0]      res_r [1:PIPE_LAT-1];

    // Stage 0 multiplies, stage 1 adds and rounds, later stages only delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            mul_r <= '0;
            c_r   <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                id_r[i] <= '0;
            end
            for (int i = 1; i < PIPE_LAT; i++) begin
                res_r[i] <= '0;
            end
        end else if (en) begin
            vld_r    <= {vld_r[PIPE_LAT-2:0], acc_vld};
            id_r[0]  <= acc_id;
            mul_r    <= P_W'(a_op) * P_W'(b_op);
            c_r      <= c_op;
            res_r[1] <= round_res(mul_r + c_r);
            for (int i = 1; i < PIPE_LAT; i++) begin
                id_r[i] <= id_r[i-1];
            end
            for (int i = 2; i < PIPE_LAT; i++) begin
                res_r[i] <= res_r[i-1];
            end
        end
    end

    assign res_vld = vld_r[PIPE_LAT-1];
    assign res     = res_r[PIPE_LAT-1];
    assign res_id  = id_r[PIPE_LAT-1];
    assign any_vld = |vld_r;

endmodule

// File: rtl/dsp48e_mac_arbiter.sv
// Round-robin arbiter sharing one multiply-add-round pipe among NREQ requesters.
// Optional CONV_ROUND_EN selects convergent rounding instead of truncation.
module dsp48e_mac_arbiter
    import dsp48e_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ*A_W-1:0]       AIN,
    input  logic [NREQ*B_W-1:0]       BIN,
    input  logic [NREQ*C_W-1:0]       CIN,
    output logic [NREQ-1:0]           GNT,
    output logic [OUT_W-1:0]          ROUND_OUT,
    output logic [$clog2(NREQ)-1:0]   OUT_ID,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic                      BUSY
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]        ptr_r;
    logic [IDW-1:0]        gnt_idx_s;
    logic [NREQ-1:0]       gnt_s;
    logic                  en_s;
    logic                  accept_s;
    int                    dist_s;
    int                    best_d_s;
    logic signed [A_W-1:0] a_sel_s;
    logic signed [B_W-1:0] b_sel_s;
    logic signed [C_W-1:0] c_sel_s;

    assign en_s = !(OUT_VALID && !OUT_READY);

    // Pick the requester closest after the pointer; grant only when running.
    always_comb begin
        best_d_s  = NREQ;
        dist_s    = 0;
        gnt_idx_s = ptr_r;
        gnt_s     = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (REQ[j]) begin
                dist_s = (j + NREQ - 1 - int'(ptr_r)) % NREQ;
                if (dist_s < best_d_s) begin
                    best_d_s  = dist_s;
                    gnt_idx_s = IDW'(j);
                end else begin
                    best_d_s  = best_d_s;
                end
            end else begin
                dist_s = dist_s;
            end
        end
        if (en_s && RST_N && (best_d_s < NREQ)) begin
            for (int j = 0; j < NREQ; j++) begin
                gnt_s[j] = (gnt_idx_s == IDW'(j));
            end
        end else begin
            gnt_s = '0;
        end
    end

    assign GNT      = gnt_s;
    assign accept_s = |(REQ & gnt_s);

    // One-hot AND-OR operand mux driven by the grant.
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        c_sel_s = '0;
        for (int j = 0; j < NREQ; j++) begin
            a_sel_s = a_sel_s | (AIN[j*A_W +: A_W] & {A_W{gnt_s[j]}});
            b_sel_s = b_sel_s | (BIN[j*B_W +: B_W] & {B_W{gnt_s[j]}});
            c_sel_s = c_sel_s | (CIN[j*C_W +: C_W] & {C_W{gnt_s[j]}});
        end
    end

    // Round-robin pointer moves only on an accept; reset makes requester 0 first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_r <= IDW'(NREQ - 1);
        end else if (accept_s) begin
            ptr_r <= gnt_idx_s;
        end
    end

    mult_round_pipe #(
        .PIPE_LAT (PIPE_LAT),
        .IDW      (IDW)
    ) u_pipe (
        .clk     (CLK),
        .rst_n   (RST_N),
        .en      (en_s),
        .acc_vld (accept_s),
        .a_op    (a_sel_s),
        .b_op    (b_sel_s),
        .c_op    (c_sel_s),
        .acc_id  (gnt_idx_s),
        .res_vld (OUT_VALID),
        .res     (ROUND_OUT),
        .res_id  (OUT_ID),
        .any_vld (BUSY)
    );

endmodule

// File: tb/tb_dsp48e_mac_arbiter.sv
// Scoreboard bench for dsp48e_mac_arbiter: accepts push expected results, a monitor pops on transfer.
// Expected values follow CONV_ROUND_EN when the bench is built with it.
module tb_dsp48e_mac_arbiter;

`ifdef CONV_ROUND_EN
    localparam bit CONV = 1'b1;
`else
    localparam bit CONV = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [43:0] res;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [99:0]  ain;
    logic [71:0]  bin;
    logic [191:0] cin;
    logic [3:0]   gnt;
    logic [43:0]  round_out;
    logic [1:0]   out_id;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    exp_t         exp_q [$];
    logic [43:0]  pend_exp [4];
    logic [3:0]   acc_seen;
    int           total;
    int           bad;

    dsp48e_mac_arbiter #(.NREQ(4), .PIPE_LAT(3)) dut (
        .CLK(clk), .RST_N(rst_n), .REQ(req), .AIN(ain), .BIN(bin), .CIN(cin),
        .GNT(gnt), .ROUND_OUT(round_out), .OUT_ID(out_id), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic set_op(input int i, input logic signed [24:0] a, input logic signed [17:0] b,
                          input logic signed [47:0] c, input logic [43:0] e);
        ain[i*25 +: 25] = a;
        bin[i*18 +: 18] = b;
        cin[i*48 +: 48] = c;
        pend_exp[i]     = e;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req != 4'b0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            req = req & ~acc_seen;
            n++;
        end
        chk("drain_done", 64'(n < budget), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic issue(input int i, input logic signed [24:0] a, input logic signed [17:0] b,
                         input logic signed [47:0] c, input logic [43:0] e);
        set_op(i, a, b, c, e);
        req[i] = 1'b1;
        drain(30);
    endtask

    // Monitor: pop and compare on each transfer, then log this cycle's accepts.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            acc_seen = 4'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected actual id=%0d res=%h required=none", out_id, round_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_id", 64'(out_id), 64'(e.id));
                    chk("round_out", 64'(round_out), 64'(e.res));
                end
            end
            acc_seen = req & gnt;
            for (int i = 0; i < 4; i++) begin
                if (acc_seen[i]) begin
                    e.id  = 2'(i);
                    e.res = pend_exp[i];
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt, first, last;
        total = 0;
        bad = 0;
        rst_n = 1'b1;
        req = 4'b0;
        ain = '0;
        bin = '0;
        cin = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) pend_exp[i] = 44'd0;

        // Reset state, requests held high during reset
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 25'sd1, 18'sd1, 48'sd0, 44'd0);
        req = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_round", 64'(round_out), 64'd0);
        chk("rst_id", 64'(out_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        req = 4'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request 0, latency check
        set_op(0, 25'sd1, 18'sd520, 48'sd7, CONV ? 44'h21 : 44'h20);
        req[0] = 1'b1;
        @(negedge clk);
        chk("t2_gnt", 64'(gnt), 64'd1);
        @(posedge clk);
        #1 req[0] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        chk("t2_latency", 64'(lat), 64'd3);
        drain(20);

        // Tie, sign, overflow and extreme-product vectors
        issue(1, 25'sd24, 18'sd1, 48'sd0, CONV ? 44'd2 : 44'd1);
        issue(2, 25'sd8, 18'sd1, 48'sd0, 44'd0);
        issue(3, 25'sd24, 18'sd1, 48'sd7, CONV ? 44'd2 : 44'd1);
        issue(0, -25'sd3, 18'sd5, 48'sd0, 44'hFFF_FFFF_FFFF);
        issue(1, 25'sd0, 18'sd0, 48'h7FFF_FFFF_FFFF, CONV ? 44'h800_0000_0000 : 44'h7FF_FFFF_FFFF);
        issue(2, 25'sh100_0000, 18'sh2_0000, 48'sd0, 44'h020_0000_0000);
        issue(3, 25'sd100, -18'sd7, -48'sd5, CONV ? 44'hFFF_FFFF_FFD4 : 44'hFFF_FFFF_FFD3);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) set_op(i, 25'sd1, 18'sd16, 48'sd0, 44'd9);
        req = 4'b0111;
        repeat (3) begin
            @(posedge clk);
            #1;
            req = req & ~acc_seen;
        end
        chk("rif_busy", 64'(busy), 64'd1);
        chk("rif_valid_pre", 64'(out_valid), 64'd1);
        req = 4'hF;
        rst_n = 1'b0;
        #1;
        chk("rif_valid", 64'(out_valid), 64'd0);
        chk("rif_round", 64'(round_out), 64'd0);
        chk("rif_id", 64'(out_id), 64'd0);
        chk("rif_busy0", 64'(busy), 64'd0);
        chk("rif_gnt", 64'(gnt), 64'd0);
        exp_q.delete();
        req = 4'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rif_no_ghost", 64'(cnt), 64'd0);

        // All four held high for 8 cycles: strict rotation, back-to-back results
        for (int i = 0; i < 4; i++) set_op(i, 25'(i + 1), 18'sd16, 48'sd0, 44'(i + 1));
        @(posedge clk);
        #1 req = 4'hF;
        cnt = 0;
        first = -1;
        last = -1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k < 8) chk("rr_gnt", 64'(gnt), 64'd1 << (k % 4));
            if (out_valid) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
            @(posedge clk);
            #1;
            if (k == 7) req = 4'b0;
        end
        chk("rr_first", 64'(first), 64'd3);
        chk("rr_last", 64'(last), 64'd10);
        chk("rr_count", 64'(cnt), 64'd8);
        chk("rr_queue", 64'(exp_q.size()), 64'd0);

        // Backpressure: consumer stalls 5 cycles with the pipe full
        req = 4'hF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 7) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_id", 64'(out_id), 64'd0);
                chk("stall_res", 64'(round_out), 64'd1);
                chk("stall_gnt", 64'(gnt), 64'd0);
            end
            @(posedge clk);
            #1;
            req = req & ~acc_seen;
            if (k == 2) out_ready = 1'b0;
            if (k == 7) out_ready = 1'b1;
        end
        drain(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp48e_mac_arbiter.md
DSP48E_MAC_ARBITER -- requirements
Module: dsp48e_mac_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one multiply-add-round unit; legal range 2..8.
REQ-002 Parameter: PIPE_LAT, default 3, accept-to-result latency in enabled cycles; legal range 2..6.
REQ-003 Port: CLK  input  1  single clock; all logic samples on the rising edge.
REQ-004 Port: RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: REQ  input  NREQ  per-requester operand-valid; held high with stable operands until granted.
REQ-006 Port: AIN  input  NREQ*25  per-requester signed A operand; slice i is bits [25i+24:25i].
REQ-007 Port: BIN  input  NREQ*18  per-requester signed B operand; slice i is bits [18i+17:18i].
REQ-008 Port: CIN  input  NREQ*48  per-requester signed C addend; slice i is bits [48i+47:48i].
REQ-009 Port: GNT  output  NREQ  one-hot combinational grant; REQ[i]&GNT[i] is an accept.
REQ-010 Port: ROUND_OUT  output  44  signed rounded result.
REQ-011 Port: OUT_ID  output  clog2(NREQ)  index of the requester owning ROUND_OUT.
REQ-012 Port: OUT_VALID  output  1  ROUND_OUT/OUT_ID valid.
REQ-013 Port: OUT_READY  input  1  consumer ready; transfer when OUT_VALID&OUT_READY.
REQ-014 Port: BUSY  output  1  high while any accepted operation has not yet transferred.

Function
REQ-015 Result SHALL be P = A*B + C, computed as 48-bit signed two's complement, then reduced to 44 bits by removing P[3:0].
REQ-016 The unit SHALL accept at most one operation per cycle; sustained throughput one per cycle with no stall.
REQ-017 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod NREQ; pointer updates only on an accept.
REQ-018 With REQ all zero, GNT SHALL be zero and the pointer SHALL hold.
REQ-019 An operation accepted in enabled cycle t SHALL present OUT_VALID in enabled cycle t+PIPE_LAT with its OUT_ID.
REQ-020 Pipeline enable = !(OUT_VALID & !OUT_READY); when disabled, all stages, OUT_VALID, ROUND_OUT and OUT_ID SHALL hold and GNT SHALL be zero.
REQ-021 Bubbles SHALL propagate as invalid stages; OUT_VALID low between non-consecutive results.
REQ-022 Rounding overflow (P[47:4]=0x7FF_FFFF_FFFF rounding up) SHALL wrap modulo 2^44.
REQ-023 Simultaneous output transfer and new accept in one cycle SHALL both occur.

Reset
REQ-024 RST_N low SHALL immediately clear GNT, OUT_VALID, ROUND_OUT, OUT_ID, BUSY and all stage-valid bits, and set the pointer to NREQ-1 (first grant goes to requester 0).
REQ-025 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after release.
REQ-026 First accept SHALL occur no earlier than the first rising edge after RST_N deasserts.

Configuration
REQ-027 Macro CONV_ROUND_EN defined: convergent rounding -- P[3:0]>8 round up, <8 truncate, =8 round up only if P[4]=1 (ties to even).
REQ-028 Macro CONV_ROUND_EN undefined: truncation, ROUND_OUT = P[47:4]; latency and handshake unchanged.

Structure
REQ-029 Package dsp48e_arb_pkg SHALL hold A/B/C/product/output width constants (25, 18, 48, 44), fraction-bit count (4) and the tie value (4'b1000).
REQ-030 Sub-module mult_round_pipe SHALL contain the PIPE_LAT-stage multiply-add-round datapath with stage valid and ID tags, plus a shared enable; arbiter and handshake logic stay in the top.

Verification
REQ-031 Single req 0: A=1, B=520, C=7 (P=0x20F) -> OUT_VALID after 3 cycles, ROUND_OUT=0x21, OUT_ID=0 (0x20 with macro off).
REQ-032 Tie cases with macro on: A=24,B=1,C=0 (P=0x18) -> 2; A=8,B=1,C=0 (P=0x8) -> 0; A=24,B=1,C=7 (P=0x1F) -> 2.
REQ-033 All four REQ held high for 8 cycles -> GNT order 0,1,2,3,0,1,2,3; OUT_ID sequence identical, back-to-back.
REQ-034 OUT_READY low for 5 cycles with pipe full -> outputs held stable, GNT=0, no loss or duplication after release.
REQ-035 RST_N pulsed low with 3 operations in flight -> outputs zero immediately, no result after release, next grant to requester 0.
REQ-036 Negative operands: A=-3, B=5, C=0 (P=-15=...FF1) -> ROUND_OUT=-1 (0xFFF_FFFF_FFFF) both with and without macro.
